core_multicycle_ctrl: RTL and testbench
=======================================

Name: core_multicycle_ctrl

Overview:
Multi-cycle control sequencer for the RV32I-subset microprocessor datapath (register bank, PC, ALU, memory ports). Fetches one instruction at a time over a req/ready instruction port and latches the opcode. It then steps through DECODE/EXEC/MEM/WB and drives the datapath enables, including regwrite, memread, memwrite, memtoreg and the PC update.
Supported opcodes: R-type add/sub, I-type addi, load, store, beq, jal. Any other opcode halts the core.

Parameters:
DATA_WIDTH, 32, instruction width
CNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock
arst_n  in  1  asynchronous active-low reset
run  in  1  allow new fetch; sampled only in FETCH
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid this cycle
instruction  in  DATA_WIDTH  fetched word, valid when imem_ready
ir_we  out  1  latch instruction into datapath IR
dmem_req  out  1  data memory request
dmem_ready  in  1  data access complete this cycle
alu_zero  in  1  ALU result == 0 (beq compare)
regwrite  out  1  register bank write enable
memread  out  1  data read strobe
memwrite  out  1  data write strobe
memtoreg  out  1  writeback selects memory data
link_sel  out  1  writeback selects PC+4 (jal)
alusrc  out  1  0 = rs2, 1 = immediate
aluop  out  2  00 add, 01 sub, 10 funct-decoded
pc_we  out  1  PC update pulse
pc_src  out  1  0 = PC+4, 1 = PC+imm
halted  out  1  illegal opcode seen
state  out  3  FSM state for debug
instret  out  CNT_WIDTH  retired instruction count

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset (async, arst_n low):
  - state=FETCH, instret=0, halted=0.
  - All other outputs 0. Any pending memory request is abandoned.
- Output timing:
  - Outputs not listed for a state are 0.
  - Strobes are combinational from state and the latched opcode.
- FETCH:
  - If run=0: imem_req=0, stay in FETCH.
  - If run=1: imem_req=1. imem_req stays high until imem_ready.
  - On imem_ready: ir_we=1 that cycle, opcode = instruction[6:0] latched, go to DECODE.
- DECODE (1 cycle):
  - Legal opcode (0110011, 0010011, 0000011, 0100011, 1100011, 1101111) -> EXEC.
  - Any other opcode -> HALT.
- EXEC (1 cycle), by opcode:
  - R-type: aluop=10, alusrc=0. Next: WB.
  - addi: aluop=00, alusrc=1. Next: WB.
  - load/store: aluop=00, alusrc=1. Next: MEM.
  - beq: aluop=01, alusrc=0, pc_we=1, pc_src=alu_zero, instret+1. Next: FETCH.
  - jal: no ALU strobes. Next: WB.
- MEM (load or store):
  - dmem_req=1. memread=1 for load, memwrite=1 for store.
  - All three are held stable until dmem_ready.
  - Load on dmem_ready: go to WB.
  - Store on dmem_ready: pc_we=1, pc_src=0, instret+1 that cycle, then FETCH.
- WB (1 cycle):
  - regwrite=1, pc_we=1, instret+1. Next: FETCH.
  - Load: memtoreg=1.
  - jal: link_sel=1 and pc_src=1. All other opcodes: pc_src=0.
- HALT:
  - halted=1. No requests, no strobes, instret frozen.
  - Stays in HALT until reset.
- Cycle counts with zero-wait memory (ready in the request cycle):
  - R/I-type and jal: 4 cycles.
  - beq: 3 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
  - Each wait cycle adds 1.
- Invariants:
  - pc_we pulses exactly once per retired instruction, always in the same cycle as the instret increment.
  - regwrite and memwrite are never high in the same cycle.
  - memread and memwrite are never high in the same cycle.
  - instret wraps from all-ones to 0.
- run deasserted mid-instruction has no effect; the instruction completes and the FSM then idles in FETCH.

Test Plan:
- addi, zero-wait: run=1, instruction=0x00500093, imem_ready=1 -> states 0,1,2,4. regwrite, pc_we and alusrc seen as specified, pc_src=0, instret=1 after 4 cycles.
- load, dmem_ready delayed 3 cycles: instruction=0x0000A103 -> memread and dmem_req held 4 cycles in MEM, memtoreg=1 in WB, total 8 cycles, instret=1.
- beq taken vs not taken: instruction=0x00208463. With alu_zero=1: pc_we=1, pc_src=1 in EXEC, no regwrite. With alu_zero=0: pc_src=0. Each takes 3 cycles.
- jal: instruction=0x008000EF -> WB has regwrite=1, link_sel=1, pc_src=1, pc_we=1.
- illegal opcode 0x0000007F -> HALT, halted=1, no pc_we and no imem_req for 100 cycles. Then arst_n pulse -> FETCH, halted=0, instret=0.
- run=0 holds FETCH with imem_req=0. Separately, arst_n asserted during MEM with dmem_req=1 -> all outputs 0 immediately (asynchronously), state=0.

Source files
------------

// File: rtl/core_multicycle_ctrl_if.sv
// Control-sequencer bundle: instruction/data handshakes, datapath strobes and status.
// The master modport belongs to the sequencer; the slave side is the datapath and memories.
interface core_multicycle_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
);
    logic                  run;
    logic                  imem_req;
    logic                  imem_ready;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  ir_we;
    logic                  dmem_req;
    logic                  dmem_ready;
    logic                  alu_zero;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
    logic                  memtoreg;
    logic                  link_sel;
    logic                  alusrc;
    logic [1:0]            aluop;
    logic                  pc_we;
    logic                  pc_src;
    logic                  halted;
    logic [2:0]            state;
    logic [CNT_WIDTH-1:0]  instret;

    modport master (
        input  run, imem_ready, instruction, dmem_ready, alu_zero,
        output imem_req, ir_we, dmem_req, regwrite, memread, memwrite, memtoreg,
               link_sel, alusrc, aluop, pc_we, pc_src, halted, state, instret
    );

    modport slave (
        output run, imem_ready, instruction, dmem_ready, alu_zero,
        input  imem_req, ir_we, dmem_req, regwrite, memread, memwrite, memtoreg,
               link_sel, alusrc, aluop, pc_we, pc_src, halted, state, instret
    );
endinterface

// File: rtl/core_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I subset.
// All strobes are decoded combinationally from the state and the latched opcode.
module core_multicycle_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input logic                   clk,
    input logic                   arst_n,
    core_multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    state_e               state_q, state_d;
    logic [6:0]           opcode_q, opcode_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;
    logic                 retire;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= StFetch;
            opcode_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        retire       = 1'b0;
        bus.imem_req = 1'b0;
        bus.ir_we    = 1'b0;
        bus.dmem_req = 1'b0;
        bus.regwrite = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        bus.memtoreg = 1'b0;
        bus.link_sel = 1'b0;
        bus.alusrc   = 1'b0;
        bus.aluop    = 2'b00;
        bus.pc_we    = 1'b0;
        bus.pc_src   = 1'b0;
        bus.halted   = 1'b0;

        unique case (state_q)
            StFetch: begin
                // Qualified by arst_n so a request never leaks out while reset is held.
                if (bus.run && arst_n) begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ready) begin
                        bus.ir_we = 1'b1;
                        opcode_d  = bus.instruction[6:0];
                        state_d   = StDecode;
                    end
                end
            end
            StDecode: begin
                case (opcode_q)
                    OpR, OpImm, OpLoad, OpStore, OpBranch, OpJal: state_d = StExec;
                    default:                                       state_d = StHalt;
                endcase
            end
            StExec: begin
                case (opcode_q)
                    OpR: begin
                        bus.aluop = 2'b10;
                        state_d   = StWb;
                    end
                    OpImm: begin
                        bus.alusrc = 1'b1;
                        state_d    = StWb;
                    end
                    OpLoad, OpStore: begin
                        bus.alusrc = 1'b1;
                        state_d    = StMem;
                    end
                    OpBranch: begin
                        bus.aluop  = 2'b01;
                        bus.pc_we  = 1'b1;
                        bus.pc_src = bus.alu_zero;
                        retire     = 1'b1;
                        state_d    = StFetch;
                    end
                    OpJal:   state_d = StWb;
                    default: state_d = StHalt;
                endcase
            end
            StMem: begin
                bus.dmem_req = 1'b1;
                bus.memread  = (opcode_q == OpLoad);
                bus.memwrite = (opcode_q == OpStore);
                if (bus.dmem_ready) begin
                    if (opcode_q == OpStore) begin
                        bus.pc_we = 1'b1;
                        retire    = 1'b1;
                        state_d   = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                bus.regwrite = 1'b1;
                bus.pc_we    = 1'b1;
                bus.memtoreg = (opcode_q == OpLoad);
                bus.link_sel = (opcode_q == OpJal);
                bus.pc_src   = (opcode_q == OpJal);
                retire       = 1'b1;
                state_d      = StFetch;
            end
            StHalt:  bus.halted = 1'b1;
            default: state_d = StHalt;
        endcase

        instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, retire};
    end

    assign bus.state   = state_q;
    assign bus.instret = instret_q;
endmodule

// File: tb/tb_core_multicycle_ctrl.sv
// Randomized bench for core_multicycle_ctrl: a per-instruction cycle plan built from the
// opcode rules is replayed against the DUT and every cycle's outputs are compared.
module tb_core_multicycle_ctrl;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    core_multicycle_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    core_multicycle_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.master)
    );

    // One clock cycle: the inputs to apply and the outputs the design must show.
    typedef struct packed {
        logic          run;
        logic          iready;
        logic          dready;
        logic          zero;
        logic [DW-1:0] instr;
        logic [2:0]    st;
        logic          imem_req;
        logic          ir_we;
        logic          dmem_req;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          memtoreg;
        logic          link_sel;
        logic          alusrc;
        logic [1:0]    aluop;
        logic          pc_we;
        logic          pc_src;
        logic          halted;
        logic          retire;
    } cyc_t;

    cyc_t          plan[$];
    logic [CW-1:0] instret_m;
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [6:0]    legal_ops [6];
    logic [16:0]   obs;

    assign obs = {bus.state, bus.imem_req, bus.ir_we, bus.dmem_req, bus.regwrite, bus.memread,
                  bus.memwrite, bus.memtoreg, bus.link_sel, bus.alusrc, bus.aluop, bus.pc_we,
                  bus.pc_src, bus.halted};

    function automatic logic [16:0] exp_vec(input cyc_t c);
        return {c.st, c.imem_req, c.ir_we, c.dmem_req, c.regwrite, c.memread, c.memwrite,
                c.memtoreg, c.link_sel, c.alusrc, c.aluop, c.pc_we, c.pc_src, c.halted};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Cycle with only the don't-care inputs randomized.
    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        logic [31:0] r;
        r       = $urandom();
        c       = '0;
        c.st    = st;
        c.run   = r[0];
        c.zero  = r[1];
        c.instr = $urandom();
        return c;
    endfunction

    task automatic plan_instr(input logic [DW-1:0] ins, input int iwait, input int dwait,
                              input logic zero);
        cyc_t       c;
        logic [6:0] op;
        logic       is_ld, is_st;
        op    = ins[6:0];
        is_ld = (op == OpLoad);
        is_st = (op == OpStore);
        for (int i = 0; i < iwait; i++) begin
            c          = blank(3'd0);
            c.run      = 1'b1;
            c.imem_req = 1'b1;
            plan.push_back(c);
        end
        c          = blank(3'd0);
        c.run      = 1'b1;
        c.iready   = 1'b1;
        c.instr    = ins;
        c.imem_req = 1'b1;
        c.ir_we    = 1'b1;
        plan.push_back(c);
        plan.push_back(blank(3'd1));
        if (!(op inside {OpR, OpImm, OpLoad, OpStore, OpBranch, OpJal})) return;

        c      = blank(3'd2);
        c.zero = zero;
        case (op)
            OpR:            c.aluop = 2'b10;
            OpImm:          c.alusrc = 1'b1;
            OpLoad, OpStore: c.alusrc = 1'b1;
            OpBranch: begin
                c.aluop  = 2'b01;
                c.pc_we  = 1'b1;
                c.pc_src = zero;
                c.retire = 1'b1;
            end
            default: ;
        endcase
        plan.push_back(c);
        if (op == OpBranch) return;

        if (is_ld || is_st) begin
            for (int i = 0; i <= dwait; i++) begin
                c          = blank(3'd3);
                c.dready   = (i == dwait);
                c.dmem_req = 1'b1;
                c.memread  = is_ld;
                c.memwrite = is_st;
                if (is_st && i == dwait) begin
                    c.pc_we  = 1'b1;
                    c.retire = 1'b1;
                end
                plan.push_back(c);
            end
        end
        if (is_st) return;

        c          = blank(3'd4);
        c.regwrite = 1'b1;
        c.pc_we    = 1'b1;
        c.retire   = 1'b1;
        c.memtoreg = is_ld;
        c.link_sel = (op == OpJal);
        c.pc_src   = (op == OpJal);
        plan.push_back(c);
    endtask

    task automatic plan_idle(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c     = blank(3'd0);
            c.run = 1'b0;
            plan.push_back(c);
        end
    endtask

    task automatic plan_halt(input int n);
        cyc_t c;
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r        = $urandom();
            c        = blank(3'd5);
            c.iready = r[0];
            c.dready = r[1];
            c.halted = 1'b1;
            plan.push_back(c);
        end
    endtask

    task automatic run_plan(input int max);
        cyc_t c;
        int   done;
        done = 0;
        while (plan.size() > 0 && done < max) begin
            c = plan.pop_front();
            @(negedge clk);
            bus.run         = c.run;
            bus.imem_ready  = c.iready;
            bus.dmem_ready  = c.dready;
            bus.alu_zero    = c.zero;
            bus.instruction = c.instr;
            #1;
            check_eq("ctl", 32'(obs), 32'(exp_vec(c)));
            check_eq("instret", 32'(bus.instret), 32'(instret_m));
            if (c.retire) instret_m = instret_m + 1'b1;
            done++;
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  op;
        legal_ops = '{OpR, OpImm, OpLoad, OpStore, OpBranch, OpJal};
        instret_m = '0;

        // Reset with run and ready high: nothing may leak out.
        arst_n          = 1'b0;
        bus.run         = 1'b1;
        bus.imem_ready  = 1'b1;
        bus.dmem_ready  = 1'b1;
        bus.alu_zero    = 1'b1;
        bus.instruction = 32'h00500093;
        #2;
        check_eq("rst_ctl", 32'(obs), 32'h0);
        check_eq("rst_instret", 32'(bus.instret), 32'h0);
        @(negedge clk);
        bus.run        = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        arst_n         = 1'b1;

        plan_instr(32'h00500093, 0, 0, 1'b0);
        plan_instr(32'h0000A103, 0, 3, 1'b0);
        plan_instr(32'h00208463, 0, 0, 1'b1);
        plan_instr(32'h00208463, 0, 0, 1'b0);
        plan_instr(32'h008000EF, 0, 0, 1'b0);
        plan_instr(32'h0020A223, 2, 0, 1'b0);
        plan_instr(32'h402081B3, 1, 0, 1'b0);
        plan_idle(5);
        run_plan(1000);

        for (int n = 0; n < 200; n++) begin
            r  = $urandom();
            op = legal_ops[$urandom_range(0, 5)];
            plan_instr({r[31:7], op}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       r[0]);
            if (r[1]) plan_idle(int'($urandom_range(1, 2)));
            run_plan(1000);
        end

        plan_instr(32'h0000007F, 0, 0, 1'b0);
        plan_halt(100);
        run_plan(1000);

        @(negedge clk);
        bus.run = 1'b0;
        arst_n  = 1'b0;
        #1;
        check_eq("halt_rst_ctl", 32'(obs), 32'h0);
        check_eq("halt_rst_instret", 32'(bus.instret), 32'h0);
        #2;
        arst_n    = 1'b1;
        instret_m = '0;
        plan_idle(2);
        plan_instr(32'h00500093, 0, 0, 1'b0);
        run_plan(1000);

        // Reset while a load sits in MEM with dmem_req high.
        plan_instr(32'h0000A103, 0, 6, 1'b0);
        run_plan(5);
        check_eq("mem_req_before_rst", 32'(bus.dmem_req), 32'h1);
        bus.run = 1'b1;
        #1;
        arst_n = 1'b0;
        #1;
        check_eq("mem_rst_ctl", 32'(obs), 32'h0);
        check_eq("mem_rst_instret", 32'(bus.instret), 32'h0);
        plan.delete();
        @(negedge clk);
        bus.run        = 1'b0;
        bus.dmem_ready = 1'b0;
        arst_n         = 1'b1;
        instret_m      = '0;
        plan_instr(32'h002081B3, 0, 0, 1'b0);
        plan_idle(2);
        run_plan(1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
